dmem_ws_ctrl: RTL and testbench

//  Parametrised data-memory controller for the darkriscv core. Successor to the flat zero-wait ram model.

---
 rtl/dmem_ws_ctrl.sv | 150 +++++++++++++++
 tb/tb_dmem_ws_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ws_ctrl.sv
// dmem_ws_ctrl: data-memory controller for the darkriscv data port.
// Byte-enable writes, WAIT_CYC programmable wait states, HLT stall to the core,
// address window [BASE_ADDR, BASE_ADDR + 4*2**DEPTH_LOG2) and a sticky ERR flag.
// Optional feature macro: DMEM_PERF_EN adds a stall-cycle counter on o_perf;
// without it o_perf is tied to zero.
// DEPTH_LOG2 must stay below 30 so the window size fits in 32 bits.

// One byte lane of the word array; contents are never reset.
module dmem_ws_lane #(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [0:(1<<AW)-1];

    // byte write on the completing edge
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_idx] <= i_wdata;
    end

    assign o_rdata = r_mem[i_idx];
endmodule

module dmem_ws_ctrl #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          WAIT_CYC   = 0
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_datao,
    input  logic [3:0]  i_be,
    input  logic        i_wr,
    input  logic        i_rd,
    output logic [31:0] o_datai,
    output logic        o_hlt,
    output logic        o_err,
    output logic [31:0] o_perf
);
    localparam int          NUM_LANES = 4;
    localparam logic [31:0] WIN_BYTES = 32'(4) << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                          r_state, w_next;
    logic [3:0]                      r_cnt;
    logic [31:0]                     r_datai;
    logic                            r_err;
    logic                            w_req, w_fire, w_hlt, w_inwin;
    logic [31:0]                     w_off;
    logic [DEPTH_LOG2-1:0]           w_idx;
    logic [NUM_LANES-1:0][7:0]       w_rdata;

    assign w_req = i_rd | i_wr;

    // Offset compare covers both the low bound (wrap makes it huge) and the
    // high bound; the low address bits take part so none are left dangling.
    assign w_off   = i_daddr - BASE_ADDR;
    assign w_inwin = (i_daddr >= BASE_ADDR) && (w_off < WIN_BYTES);
    assign w_idx   = w_off[DEPTH_LOG2+1:2];

    // state register and wait-state counter
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE)
                r_cnt <= 4'(WAIT_CYC);
            else if (r_state == S_BUSY && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    // next-state: a request seen in DONE waits for the following IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next = S_BUSY;
            S_BUSY:  if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // outputs: stall and access strobe; both suppressed while in reset so an
    // abandoned access never commits a write
    always_comb begin
        w_hlt  = 1'b0;
        w_fire = 1'b0;
        if (!i_res) begin
            w_hlt  = (r_state == S_IDLE && w_req) || (r_state == S_BUSY);
            w_fire = (r_state == S_BUSY) && (r_cnt == 4'd0) && w_req;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            dmem_ws_lane #(.AW(DEPTH_LOG2)) u_lane (
                .i_clk   (i_clk),
                .i_we    (w_fire & i_wr & w_inwin & i_be[g]),
                .i_idx   (w_idx),
                .i_wdata (i_datao[8*g +: 8]),
                .o_rdata (w_rdata[g])
            );
        end
    endgenerate

    // read data and sticky error; a plain write leaves DATAI untouched
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_datai <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_fire) begin
            if (!w_inwin) begin
                r_datai <= 32'd0;
                r_err   <= 1'b1;
            end else if (i_wr) begin
                if (i_rd) r_datai <= 32'd0;
            end else begin
                r_datai <= w_rdata;
            end
        end
    end

`ifdef DMEM_PERF_EN
    logic [31:0] r_perf;

    // stall-cycle counter, wraps naturally
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) r_perf <= 32'd0;
        else if (w_hlt) r_perf <= r_perf + 32'd1;
    end

    assign o_perf = r_perf;
`else
    assign o_perf = 32'h0;
`endif

    assign o_datai = r_datai;
    assign o_hlt   = w_hlt;
    assign o_err   = r_err;
endmodule

// File: tb/tb_dmem_ws_ctrl.sv
// Bench for dmem_ws_ctrl: two instances (A: zero wait, 1K words at 0;
// B: 3 wait states, 16 words at 0x100), table-driven accesses with a
// scoreboard queue, plus hand sequences for reset, back-to-back and
// reset-during-BUSY.
module tb_dmem_ws_ctrl;
    localparam int WA = 0;
    localparam int WB = 3;
    localparam int LA = WA + 2;
    localparam int LB = WB + 2;

    logic        clk;
    logic        rst   [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] daddr [2];
    logic [31:0] datao [2];
    logic [3:0]  be    [2];
    logic [31:0] datai [2];
    logic [31:0] perf  [2];
    logic        hlt   [2];
    logic        err   [2];

    int errs   = 0;
    int checks = 0;
    int sum_lat [2];

    typedef struct {
        int          d;
        logic        rd, wr;
        logic [31:0] addr, data;
        logic [3:0]  be;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    vec_t tv [$];
    exp_t sbq [$];

    dmem_ws_ctrl #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .WAIT_CYC(WA)) u_a (
        .i_clk(clk), .i_res(rst[0]), .i_daddr(daddr[0]), .i_datao(datao[0]),
        .i_be(be[0]), .i_wr(wr[0]), .i_rd(rd[0]), .o_datai(datai[0]),
        .o_hlt(hlt[0]), .o_err(err[0]), .o_perf(perf[0]));

    dmem_ws_ctrl #(.DEPTH_LOG2(4), .BASE_ADDR(32'h100), .WAIT_CYC(WB)) u_b (
        .i_clk(clk), .i_res(rst[1]), .i_daddr(daddr[1]), .i_datao(datao[1]),
        .i_be(be[1]), .i_wr(wr[1]), .i_rd(rd[1]), .o_datai(datai[1]),
        .o_hlt(hlt[1]), .o_err(err[1]), .o_perf(perf[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] dat, input logic [3:0] b, input logic cd,
                       input logic [31:0] ed, input logic ee);
        vec_t v;
        v.d = d; v.rd = r; v.wr = w; v.addr = a; v.data = dat; v.be = b;
        v.chk_data = cd; v.exp_data = ed; v.exp_err = ee;
        v.exp_lat = (d == 0) ? LA : LB;
        tv.push_back(v);
    endtask

    function automatic logic [31:0] exp_perf(input int d);
`ifdef DMEM_PERF_EN
        return 32'(sum_lat[d]);
`else
        return (d < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    // drive one access, count stall cycles, compare at the DONE cycle
    task automatic run_vec(input int n, input vec_t v);
        exp_t e;
        exp_t got;
        int   lat;
        bit   done;
        @(negedge clk);
        rd[v.d] = v.rd; wr[v.d] = v.wr; daddr[v.d] = v.addr;
        datao[v.d] = v.data; be[v.d] = v.be;
        e.chk_data = v.chk_data; e.data = v.exp_data; e.err = v.exp_err; e.lat = v.exp_lat;
        sbq.push_back(e);
        sum_lat[v.d] += v.exp_lat;
        #1;
        lat = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (hlt[v.d]) begin
                lat++;
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            checks++; errs++;
            $display("FAIL v%0d_timeout: HLT still high after 40 cycles", n);
        end
        if (sbq.size() != 0) begin
            got = sbq.pop_front();
            chk($sformatf("v%0d_lat", n), 32'(lat), 32'(got.lat));
            chk($sformatf("v%0d_err", n), {31'd0, err[v.d]}, {31'd0, got.err});
            if (got.chk_data) chk($sformatf("v%0d_data", n), datai[v.d], got.data);
        end
        rd[v.d] = 1'b0; wr[v.d] = 1'b0;
    endtask

    initial begin
        logic [5:0]  pat;
        logic [31:0] b2b_data;
        vec_t        v;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b1; wr[d] = 1'b0; daddr[d] = '0;
            datao[d] = '0; be[d] = '0; sum_lat[d] = 0;
        end

        // reset state, with a request pending: HLT must stay low
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_hlt%0d", d), {31'd0, hlt[d]}, 32'd0);
            chk($sformatf("rst_data%0d", d), datai[d], 32'd0);
            chk($sformatf("rst_err%0d", d), {31'd0, err[d]}, 32'd0);
            chk($sformatf("rst_perf%0d", d), perf[d], 32'd0);
        end
        @(negedge clk); rd[0] = 1'b0; rd[1] = 1'b0;
        @(negedge clk); rst[0] = 1'b0; rst[1] = 1'b0;

        //   d  rd wr addr           data           be       chk expdata        err
        add(0, 0, 1, 32'h0000_0010, 32'hDEADBEEF, 4'hF,    0, 32'h0,          0);
        add(0, 1, 0, 32'h0000_0010, 32'h0,        4'hF,    1, 32'hDEADBEEF,   0);
        add(0, 1, 0, 32'h0000_0013, 32'h0,        4'h0,    1, 32'hDEADBEEF,   0);
        add(0, 0, 1, 32'h0000_0020, 32'h11223344, 4'hF,    0, 32'h0,          0);
        add(0, 0, 1, 32'h0000_0020, 32'hAABBCCDD, 4'b0101, 0, 32'h0,          0);
        add(0, 1, 0, 32'h0000_0020, 32'h0,        4'hF,    1, 32'h11BB33DD,   0);
        add(0, 0, 1, 32'h0000_0024, 32'h12345678, 4'hF,    0, 32'h0,          0);
        add(0, 0, 1, 32'h0000_0024, 32'hFFFFFFFF, 4'h0,    0, 32'h0,          0);
        add(0, 1, 0, 32'h0000_0024, 32'h0,        4'hF,    1, 32'h12345678,   0);
        add(0, 1, 1, 32'h0000_0028, 32'hCAFEF00D, 4'hF,    1, 32'h0,          0);
        add(0, 1, 0, 32'h0000_0028, 32'h0,        4'hF,    1, 32'hCAFEF00D,   0);
        add(0, 0, 1, 32'h0000_0008, 32'h00000808, 4'hF,    0, 32'h0,          0);
        add(0, 0, 1, 32'h0000_0FFC, 32'h0BADF00D, 4'hF,    0, 32'h0,          0);
        add(0, 1, 0, 32'h0000_0FFC, 32'h0,        4'hF,    1, 32'h0BADF00D,   0);
        add(0, 1, 0, 32'h0000_1000, 32'h0,        4'hF,    1, 32'h0,          1);
        add(0, 1, 0, 32'h0000_0010, 32'h0,        4'hF,    1, 32'hDEADBEEF,   1);
        add(1, 0, 1, 32'h0000_013C, 32'h600DCAFE, 4'hF,    0, 32'h0,          0);
        add(1, 1, 0, 32'h0000_013C, 32'h0,        4'hF,    1, 32'h600DCAFE,   0);
        add(1, 0, 1, 32'h0000_0100, 32'h01010101, 4'hF,    0, 32'h0,          0);
        add(1, 0, 1, 32'h0000_0130, 32'h00000077, 4'hF,    0, 32'h0,          0);
        add(1, 1, 0, 32'h0000_0140, 32'h0,        4'hF,    1, 32'h0,          1);
        add(1, 0, 1, 32'h0000_00FC, 32'h12121212, 4'hF,    1, 32'h0,          1);
        add(1, 1, 0, 32'h0000_013C, 32'h0,        4'hF,    1, 32'h600DCAFE,   1);
        add(1, 1, 0, 32'h0000_0100, 32'h0,        4'hF,    1, 32'h01010101,   1);

        for (int i = 0; i < tv.size(); i++) run_vec(i, tv[i]);

        // back-to-back read held through DONE on the zero-wait instance
        @(negedge clk);
        rd[0] = 1'b1; daddr[0] = 32'h8; be[0] = 4'hF;
        #1 pat[5] = hlt[0];
        for (int k = 1; k < 6; k++) begin
            @(negedge clk);
            pat[5-k] = hlt[0];
        end
        b2b_data = datai[0];
        rd[0] = 1'b0;
        sum_lat[0] += 2 * LA;
        chk("b2b_hlt_pattern", {26'd0, pat}, 32'b110110);
        chk("b2b_data", b2b_data, 32'h00000808);

        chk("perf_a", perf[0], exp_perf(0));
        chk("perf_b", perf[1], exp_perf(1));

        // reset while B is in BUSY with a write of 0x5 to 0x130
        @(negedge clk);
        wr[1] = 1'b1; daddr[1] = 32'h130; datao[1] = 32'h5; be[1] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b1; wr[1] = 1'b0;
        #1 chk("midrst_hlt", {31'd0, hlt[1]}, 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        sum_lat[1] = 0;
        chk("midrst_err", {31'd0, err[1]}, 32'd0);
        chk("midrst_perf", perf[1], 32'd0);
        v.d = 1; v.rd = 1'b1; v.wr = 1'b0; v.addr = 32'h130; v.data = 32'h0;
        v.be = 4'hF; v.chk_data = 1'b1; v.exp_data = 32'h77; v.exp_err = 1'b0;
        v.exp_lat = LB;
        run_vec(100, v);
        chk("perf_b_after_rst", perf[1], exp_perf(1));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
